// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard hazard unit: tracks the kind and pipeline age of each
// in-flight write and derives forwarding selects, stalls and redirect flushes.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int RW       = $clog2(NREG),
  parameter int MD_LAT   = 4,
  parameter bit BR_IN_ID = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_rs1_used,
  input  logic          id_rs2_used,
  input  logic [RW-1:0] id_rd,
  input  logic          id_wr,
  input  logic [1:0]    id_kind,
  input  logic          id_is_branch,
  input  logic          ex_redirect,
  output logic [1:0]    fwd_rs1_sel,
  output logic [1:0]    fwd_rs2_sel,
  output logic          pc_en,
  output logic          if_id_en,
  output logic          if_id_flush,
  output logic          id_ex_clear,
  output logic          md_busy
);

  localparam int MDW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [1:0] AGE_EX = 2'd1;
  localparam logic [1:0] AGE_WB = 2'd3;

  typedef enum logic [1:0] {
    K_ALU    = 2'd0,
    K_LOAD   = 2'd1,
    K_MULDIV = 2'd2,
    K_LINK   = 2'd3
  } kind_e;

  typedef struct packed {
    logic       pend;
    kind_e      kind;
    logic [1:0] age;
  } entry_t;

  entry_t         sb [NREG];
  logic [MDW-1:0] md_cnt;
  logic           md_act;
  logic           br_early;
  logic           redir;
  logic           stall;
  logic           issue;
  logic           hz1, hz2;
  logic [1:0]     sel1, sel2;

  // Returns {hazard, forward select} for one source operand.
  function automatic logic [2:0] eval_op(input logic used, input logic [RW-1:0] idx,
                                         input entry_t e, input logic br, input logic mdb);
    logic [1:0] need;
    logic       live;
    logic       hz;
    need = (e.kind == K_LOAD) ? 2'd2 : 2'd1;
    if (br) need = need + 2'd1;
    live = used && (idx != '0) && e.pend;
    hz   = live && ((e.age < need) ||
                    (e.kind == K_MULDIV && e.age == AGE_EX && mdb && need == 2'd1));
    if (live && !hz) return {1'b0, e.age};
    return {hz, 2'd0};
  endfunction

  // NOTE: every output gets a default before any branch, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    md_act      = (md_cnt != '0);
    br_early    = id_is_branch & BR_IN_ID;
    {hz1, sel1} = eval_op(id_rs1_used, id_rs1, sb[id_rs1], br_early, md_act);
    {hz2, sel2} = eval_op(id_rs2_used, id_rs2, sb[id_rs2], br_early, md_act);
    // EX cannot resolve a redirect while the MUL/DIV unit owns it.
    redir       = ex_redirect & ~md_act;
    stall       = id_valid & (hz1 | hz2 | md_act);
    issue       = id_valid & ~stall & ~redir;

    fwd_rs1_sel = sel1;
    fwd_rs2_sel = sel2;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_clear = 1'b0;
    md_busy     = md_act;

    if (rst) begin
      fwd_rs1_sel = 2'd0;
      fwd_rs2_sel = 2'd0;
      md_busy     = 1'b0;
    end else if (redir) begin
      if_id_flush = 1'b1;
      id_ex_clear = 1'b1;
    end else if (stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_clear = 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every entry ages from
  // the same pre-edge snapshot. The scoreboard is a flop array, not a RAM, so
  // clearing it on reset is cheap and required: stale pend bits would stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) sb[r] <= '0;
      md_cnt <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (issue && id_wr && id_rd == RW'(r)) begin
          sb[r] <= '{pend: 1'b1, kind: kind_e'(id_kind), age: AGE_EX};
        end else if (sb[r].pend) begin
          if (sb[r].age == AGE_WB)
            sb[r].pend <= 1'b0;
          else if (!(sb[r].age == AGE_EX && md_act))
            sb[r].age <= sb[r].age + 2'd1;
        end
      end

      if (issue && id_kind == K_MULDIV)
        md_cnt <= MDW'(MD_LAT - 1);
      else if (md_act)
        md_cnt <= md_cnt - MDW'(1);
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline forwarding/hazard unit.
- Replaces per-instruction opcode comparisons with a per-register scoreboard. Each entry records the producer kind and pipeline age of the in-flight write.
- From the scoreboard it derives per-operand forwarding selects for the ID stage, load-use and branch-in-ID stalls, a structural stall for a multi-cycle MUL/DIV unit, and flushes on EX redirect.
- Sits beside the ID stage; drives PC, IF/ID and ID/EX control.

Parameters:
NREG, 32, number of architectural registers; register 0 is hard-wired zero.
RW, $clog2(NREG), register index width.
MD_LAT, 4, MUL/DIV latency in EX cycles (>=1); 1 means single-cycle with no structural stall.
BR_IN_ID, 1, 1 = branches compare operands in ID and need results one stage earlier; 0 = branch treated as an ordinary consumer.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a valid instruction
id_rs1  in  RW  source register 1
id_rs2  in  RW  source register 2
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd  in  RW  destination register
id_wr  in  1  instruction writes rd
id_kind  in  2  producer kind: 0 ALU/LUI/AUIPC, 1 LOAD, 2 MULDIV, 3 JAL/JALR (link)
id_is_branch  in  1  conditional branch in ID
ex_redirect  in  1  EX resolved taken branch/jump; PC redirected
fwd_rs1_sel  out  2  0 RF, 1 EX result, 2 MEM result, 3 WB result
fwd_rs2_sel  out  2  same encoding for rs2
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  kill IF/ID contents
id_ex_clear  out  1  insert bubble into ID/EX
md_busy  out  1  MUL/DIV occupying EX

Behaviour:
- Clocking and interface: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - All entries: pend=0.
  - md_cnt=0.
  - Outputs: fwd_*_sel=0, pc_en=1, if_id_en=1, if_id_flush=0, id_ex_clear=0, md_busy=0.
  - Reset mid-MUL/DIV aborts it; md_busy=0 the next cycle.
- Entry fields per register r≠0: pend (1b), kind (2b), age (2b: 1=EX, 2=MEM, 3=WB).
- issue = id_valid & ~stall & ~ex_redirect.
  - On issue with id_wr and id_rd≠0: entry[id_rd] <= {1, id_kind, 1}.
  - The new issue overwrites any older entry for the same rd, including one retiring that cycle.
- Ageing, each cycle, for each pending entry not written by issue:
  - age 3 → pend<=0 (RF written, write-first).
  - age 1 with md_cnt≠0 → hold.
  - otherwise age<=age+1.
  - Stalls do not freeze ageing.
- MUL/DIV counter:
  - On issue with id_kind=2: md_cnt <= MD_LAT-1.
  - Else if md_cnt≠0: decrement.
  - md_busy = (md_cnt≠0).
- Required age `need`, per operand, for a pending matching entry (operand used, index≠0, pend=1):
  - kind 0/3: need 1; need 2 if id_is_branch & BR_IN_ID.
  - kind 1: need 2; need 3 if id_is_branch & BR_IN_ID.
  - kind 2: need 1 plus md_cnt=0; need 2 if id_is_branch & BR_IN_ID.
- Operand hazard = pending & (age<need | (kind=2 & age=1 & md_cnt≠0 & need=1)).
- Stall conditions (combinational):
  - stall = id_valid & (hazard_rs1 | hazard_rs2 | md_busy).
  - stall → pc_en=0, if_id_en=0, id_ex_clear=1.
- Forwarding select (combinational):
  - fwd_sel = age of the matching pending entry when not hazarded, else 0.
  - Unused operand or index 0 → 0.
- Redirect:
  - ex_redirect → if_id_flush=1, id_ex_clear=1, pc_en=1, if_id_en=1.
  - Redirect overrides stall; the ID instruction is not issued and the scoreboard is not written.
  - ex_redirect is ignored while md_busy=1 (EX holds MUL/DIV; cannot redirect).
- Latency: all outputs are combinational from current inputs and state; scoreboard updates take effect next cycle.

Test Plan:
- add x5 issued; next cycle add x6,x5,x1 → no stall, fwd_rs1_sel=1. With one instruction between them → fwd_rs1_sel=2; with two between → 3; with three between → 0.
- lw x5 then add x6,x5,x5 → exactly 1 cycle of pc_en=0, if_id_en=0, id_ex_clear=1; then fwd_rs1_sel=fwd_rs2_sel=2.
- lw x5 then beq x5,x0 with BR_IN_ID=1 → 2 stall cycles, then fwd_rs1_sel=3. With BR_IN_ID=0 → 1 stall cycle, then fwd_rs1_sel=2.
- mul x7 (MD_LAT=4) then add x8,x7,x0 → md_busy high 3 cycles and ID stalled 3 cycles; 4th cycle fwd_rs1_sel=1, no stall.
- Load-use stall active, then ex_redirect=1 → if_id_flush=1, id_ex_clear=1, pc_en=1; no entry written for the killed rd.
- Writes to x0 never cause a stall or a nonzero fwd select; rst asserted mid-mul → md_busy=0 and all fwd_sel=0 the next cycle.
